nes_clk_rst_seq: RTL and testbench
==================================

# nes_clk_rst_seq

Power-up and recovery sequencer that sits directly downstream of the NES PLL, in the DDR3 controller clock domain (pclk, fclk/4). It qualifies the PLL `lock` output and releases the DDR3 controller reset and then the NES core reset in a fixed order. It generates the main-clock and PPU clock-enable pulses (pclk/3 and pclk/18) that the core runs on. Any loss of lock or calibration drops the design back into reset and restarts the sequence.

## Interface
- `LOCK_STABLE_CYCLES`, 1024: consecutive synchronized-lock cycles required before DDR reset sequencing starts.
- `DDR_RST_CYCLES`, 200: cycles `ddr_rstn` is held low after lock qualification.
- `CALIB_TIMEOUT`, 1048576: maximum cycles spent waiting for `calib_done`. Used only with `CALIB_TIMEOUT_EN`.
- `clk`  in  1  pclk, from PLL `clkoutd`.
- `resetn`  in  1  asynchronous, active-low reset. Asynchronous assert; release is the user's responsibility.
- `pll_lock`  in  1  PLL lock, asynchronous to `clk`. Synchronized internally with 2 flops.
- `calib_done`  in  1  DDR3 controller calibration complete, synchronous to `clk`.
- `ddr_rstn`  out  1  active-low DDR3 controller reset.
- `core_rstn`  out  1  active-low NES core reset.
- `ce_main`  out  1  main-clock enable, 1-cycle pulse every 3 cycles.
- `ce_ppu`  out  1  PPU enable, 1-cycle pulse every 18 cycles.
- `ready`  out  1  high in RUN.
- `retry_cnt`  out  8  calibration-timeout retry count, saturating at 255.

## Operation
- `pll_lock` passes through a 2-flop synchronizer; its output is `lock_s`.
- One state counter `cnt` is cleared on every state entry. Its width is `$clog2` of the largest parameter.
- The state machine has five states:
  - WAIT_LOCK: entered on reset. Goes to LOCK_STABLE when `lock_s`=1.
  - LOCK_STABLE: counts cycles. Goes to DDR_RST when `cnt`==`LOCK_STABLE_CYCLES`-1 with `lock_s`=1.
  - DDR_RST: goes to CALIB when `cnt`==`DDR_RST_CYCLES`-1.
  - CALIB: goes to RUN when `calib_done`=1. Timeout behaviour is described under Configuration.
  - RUN: steady state. `calib_done`=0 goes to DDR_RST.
- `lock_s`=0 in any state other than WAIT_LOCK goes to WAIT_LOCK. This takes priority over every other transition.
- Outputs are Moore decodes of the registered state, with no extra register stage:
  - `ddr_rstn` = 1 in CALIB and RUN.
  - `core_rstn` = `ready` = 1 in RUN.
- Clock-enable generation:
  - `div3` (0..2) and `div6` (0..5) are held at 0 outside RUN.
  - In RUN, `div3` increments every cycle and wraps at 2.
  - `div6` increments when `div3`==2 and wraps at 5.
  - `ce_main` = RUN && `div3`==2.
  - `ce_ppu` = `ce_main` && `div6`==5.
  - Therefore `ce_ppu` always coincides with a `ce_main` pulse.

## Timing
- Reset values: state WAIT_LOCK; synchronizer flops 0; `cnt`, `div3`, `div6`, `retry_cnt` = 0.
- Resulting output values during reset: `ddr_rstn`, `core_rstn`, `ce_main`, `ce_ppu`, `ready` all 0; `retry_cnt` = 0.
- `pll_lock` rising, measured from the first sampling edge:
  - `lock_s` goes high at edge 2.
  - State enters LOCK_STABLE at edge 3.
  - State enters DDR_RST at edge 3+`LOCK_STABLE_CYCLES`.
  - `ddr_rstn` rises at edge 3+`LOCK_STABLE_CYCLES`+`DDR_RST_CYCLES`.
- `calib_done` sampled high in CALIB: `core_rstn` and `ready` rise at the next edge.
  - The first `ce_main` occurs 3 cycles after RUN entry.
  - The first `ce_ppu` occurs 18 cycles after RUN entry.
- Lock drop: `pll_lock` falling is followed 3 edges later by WAIT_LOCK, with all outputs low except `retry_cnt`.
  - A lock glitch shorter than one cycle may be missed; that is acceptable.
  - A glitch that reaches `lock_s` during LOCK_STABLE restarts qualification from `cnt`=0.
- Simultaneous events:
  - `lock_s` falling in the same cycle as any other transition condition: WAIT_LOCK wins.
  - `calib_done` high on the timeout cycle: RUN wins, and `retry_cnt` does not increment.
- `resetn` low mid-operation: immediate asynchronous return to reset values, including `retry_cnt`.

## Configuration
- Macro: `NES_CLK_RST_SEQ_CALIB_TIMEOUT_EN`.
- Defined: in CALIB, `cnt`==`CALIB_TIMEOUT`-1 with `calib_done`=0 goes to DDR_RST, re-pulsing `ddr_rstn` low for `DDR_RST_CYCLES`.
  - `retry_cnt` increments on each such timeout and saturates at 255.
  - `retry_cnt` clears only on `resetn`.
- Undefined: CALIB waits indefinitely for `calib_done`. `retry_cnt` is tied to 0, and the `CALIB_TIMEOUT` parameter is unused.

## Test plan
Bench parameters: `LOCK_STABLE_CYCLES`=16, `DDR_RST_CYCLES`=8, `CALIB_TIMEOUT`=64.
- Clean bring-up:
  - Stimulus: release reset; raise `pll_lock` and hold it; raise `calib_done` 10 cycles after `ddr_rstn` rises.
  - Required: `ddr_rstn` rises exactly 27 edges after `pll_lock`; `core_rstn` and `ready` rise 1 edge after `calib_done`.
  - Required: `ce_main` has period 3; `ce_ppu` has period 18 and coincides with `ce_main`.
- Lock glitch during qualification:
  - Stimulus: drop `pll_lock` for 3 cycles while in LOCK_STABLE.
  - Required: WAIT_LOCK is re-entered; `ddr_rstn` rises 27 edges after the second rise.
- Lock loss in RUN:
  - Stimulus: drop `pll_lock`.
  - Required: after 3 edges, `core_rstn`, `ddr_rstn`, `ready`, and the clock enables are 0; `div3`/`div6` restart from 0 after the next RUN entry.
- Calibration loss in RUN:
  - Stimulus: drive `calib_done`=0 for 1 cycle.
  - Required: `ddr_rstn` low for 8 cycles; `core_rstn` stays low until `calib_done` returns.
- Timeout (macro defined):
  - Stimulus: hold `calib_done`=0.
  - Required: `ddr_rstn` re-pulses low every 64+8 cycles; `retry_cnt` increments 1, 2, 3, … and saturates at 255.
  - Same stimulus, macro undefined: `ddr_rstn` stays high and `retry_cnt`=0.
- Asynchronous reset mid-RUN:
  - Stimulus: pulse `resetn` low for a fraction of one cycle.
  - Required: all outputs go to their reset values immediately; the full sequence repeats once `resetn` is released.

Source files
------------

// File: rtl/nes_clk_rst_seq_if.sv
// Sequencer-side signal bundle for nes_clk_rst_seq: PLL lock and calibration status in,
// staged resets, clock enables and retry count out.
interface nes_clk_rst_seq_if;
    localparam int unsigned RETRY_W = 8;

    logic               pll_lock;
    logic               calib_done;
    logic               ddr_rstn;
    logic               core_rstn;
    logic               ce_main;
    logic               ce_ppu;
    logic               ready;
    logic [RETRY_W-1:0] retry_cnt;

    modport master (
        input  pll_lock, calib_done,
        output ddr_rstn, core_rstn, ce_main, ce_ppu, ready, retry_cnt
    );

    modport slave (
        output pll_lock, calib_done,
        input  ddr_rstn, core_rstn, ce_main, ce_ppu, ready, retry_cnt
    );
endinterface

// File: rtl/nes_clk_rst_seq.sv
// PLL-lock qualification, staged DDR3/core reset release and pclk/3, pclk/18 enables.
// Optional calibration timeout/retry: define NES_CLK_RST_SEQ_CALIB_TIMEOUT_EN.
module nes_clk_rst_seq #(
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned DDR_RST_CYCLES     = 200,
    parameter int unsigned CALIB_TIMEOUT      = 1048576
) (
    input  logic               clk,
    input  logic               resetn,
    nes_clk_rst_seq_if.master  bus
);
    localparam int unsigned MAX_LD  = (LOCK_STABLE_CYCLES > DDR_RST_CYCLES) ?
                                      LOCK_STABLE_CYCLES : DDR_RST_CYCLES;
    localparam int unsigned CNT_MAX = (MAX_LD > CALIB_TIMEOUT) ? MAX_LD : CALIB_TIMEOUT;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DDR_LAST  = CNT_W'(DDR_RST_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_WAIT_LOCK,
        ST_LOCK_STABLE,
        ST_DDR_RST,
        ST_CALIB,
        ST_RUN
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [1:0]         div3;
    logic [2:0]         div6;
    logic               lock_meta;
    logic               lock_s;

    // Two-flop synchronizer for the asynchronous PLL lock
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= bus.pll_lock;
            lock_s    <= lock_meta;
        end
    end

    // Sequencer state, shared state counter and enable dividers (dividers live only in RUN)
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_WAIT_LOCK;
            cnt   <= '0;
            div3  <= '0;
            div6  <= '0;
        end else begin
            cnt  <= cnt + CNT_W'(1);
            div3 <= '0;
            div6 <= '0;
            if (!lock_s) begin
                state <= ST_WAIT_LOCK;
                cnt   <= '0;
            end else begin
                case (state)
                    ST_WAIT_LOCK: begin
                        state <= ST_LOCK_STABLE;
                        cnt   <= '0;
                    end
                    ST_LOCK_STABLE: begin
                        if (cnt == LOCK_LAST) begin
                            state <= ST_DDR_RST;
                            cnt   <= '0;
                        end
                    end
                    ST_DDR_RST: begin
                        if (cnt == DDR_LAST) begin
                            state <= ST_CALIB;
                            cnt   <= '0;
                        end
                    end
                    ST_CALIB: begin
                        if (bus.calib_done) begin
                            state <= ST_RUN;
                            cnt   <= '0;
                        end
`ifdef NES_CLK_RST_SEQ_CALIB_TIMEOUT_EN
                        else if (cnt == CNT_W'(CALIB_TIMEOUT - 1)) begin
                            state <= ST_DDR_RST;
                            cnt   <= '0;
                        end
`endif
                    end
                    ST_RUN: begin
                        if (!bus.calib_done) begin
                            state <= ST_DDR_RST;
                            cnt   <= '0;
                        end else begin
                            div3 <= (div3 == 2'd2) ? 2'd0 : div3 + 2'd1;
                            if (div3 == 2'd2) begin
                                div6 <= (div6 == 3'd5) ? 3'd0 : div6 + 3'd1;
                            end else begin
                                div6 <= div6;
                            end
                        end
                    end
                    default: begin
                        state <= ST_WAIT_LOCK;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

`ifdef NES_CLK_RST_SEQ_CALIB_TIMEOUT_EN
    logic [bus.RETRY_W-1:0] retry_cnt;

    // Counts calibration timeouts; a same-cycle calib_done wins, so no increment then
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            retry_cnt <= '0;
        end else if (state == ST_CALIB && lock_s && !bus.calib_done &&
                     cnt == CNT_W'(CALIB_TIMEOUT - 1) && retry_cnt != '1) begin
            retry_cnt <= retry_cnt + 8'd1;
        end
    end

    assign bus.retry_cnt = retry_cnt;
`else
    assign bus.retry_cnt = '0;
`endif

    // Moore decodes of the registered state
    assign bus.ddr_rstn  = (state == ST_CALIB) || (state == ST_RUN);
    assign bus.core_rstn = (state == ST_RUN);
    assign bus.ready     = (state == ST_RUN);
    assign bus.ce_main   = (state == ST_RUN) && (div3 == 2'd2);
    assign bus.ce_ppu    = (state == ST_RUN) && (div3 == 2'd2) && (div6 == 3'd5);

endmodule

// File: tb/tb_nes_clk_rst_seq.sv
// Self-checking bench for nes_clk_rst_seq: timestamp-based reference model checked every
// cycle, plus directed bring-up, glitch, loss, timeout and async-reset scenarios.
module tb_nes_clk_rst_seq;
    localparam int L = 16;
    localparam int D = 8;
    localparam int T = 64;

    localparam int S_DDR  = 0;
    localparam int S_CORE = 1;
    localparam int S_RDY  = 2;
    localparam int S_CEM  = 3;
    localparam int S_CEP  = 4;

    logic clk = 1'b0;
    logic resetn;
    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 1'b0;

    nes_clk_rst_seq_if bus ();

    nes_clk_rst_seq #(
        .LOCK_STABLE_CYCLES (L),
        .DDR_RST_CYCLES     (D),
        .CALIB_TIMEOUT      (T)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.master)
    );

    always #5 clk = ~clk;

    // Reference model: tracks edge count, lock run length and event timestamps
    int n = 0;
    bit s1 = 0, s2 = 0, ls = 0;
    int run_len = 0;
    bit qual = 0, in_run = 0;
    int ddr_start = 0, run_start = 0, retry = 0;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1 = 0; s2 = 0; run_len = 0; qual = 0; in_run = 0; retry = 0;
        end else begin
            n++;
            ls = s2; s2 = s1; s1 = bus.pll_lock;
            if (!ls) begin
                run_len = 0; qual = 0; in_run = 0;
            end else begin
                run_len++;
                if (!qual) begin
                    if (run_len == L + 1) begin qual = 1; ddr_start = n; end
                end else if (in_run) begin
                    if (!bus.calib_done) begin in_run = 0; ddr_start = n; end
                end else if (n > ddr_start + D) begin
                    if (bus.calib_done) begin
                        in_run = 1; run_start = n;
                    end
`ifdef NES_CLK_RST_SEQ_CALIB_TIMEOUT_EN
                    else if (n == ddr_start + D + T) begin
                        ddr_start = n;
                        if (retry < 255) retry++;
                    end
`endif
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_ddr_rstn",  int'(bus.ddr_rstn),  int'(qual && (n >= ddr_start + D)));
            chk("model_core_rstn", int'(bus.core_rstn), int'(in_run));
            chk("model_ready",     int'(bus.ready),     int'(in_run));
            chk("model_ce_main",   int'(bus.ce_main),   int'(in_run && ((n - run_start) % 3 == 2)));
            chk("model_ce_ppu",    int'(bus.ce_ppu),    int'(in_run && ((n - run_start) % 18 == 17)));
            chk("model_retry_cnt", int'(bus.retry_cnt), retry);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic steps(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            S_DDR:   return bus.ddr_rstn;
            S_CORE:  return bus.core_rstn;
            S_RDY:   return bus.ready;
            S_CEM:   return bus.ce_main;
            default: return bus.ce_ppu;
        endcase
    endfunction

    // Edges until sel reaches val, bounded by limit
    task automatic wait_for(input int sel, input logic val, input int limit,
                            input string name, output int k);
        k = 0;
        do begin
            step();
            k++;
        end while (sig(sel) !== val && k < limit);
        if (sig(sel) !== val) chk({name, "_timeout"}, int'(sig(sel)), int'(val));
    endtask

    task automatic check_ce(input string tag);
        int fm, sm, fp, sp;
        fm = 0; sm = 0; fp = 0; sp = 0;
        for (int i = 1; i <= 40; i++) begin
            if (i > 1) step();
            if (bus.ce_main) begin
                if (fm == 0) fm = i; else if (sm == 0) sm = i;
            end
            if (bus.ce_ppu) begin
                if (fp == 0) fp = i; else if (sp == 0) sp = i;
            end
        end
        chk({tag, "_first_ce_main"}, fm, 3);
        chk({tag, "_ce_main_period"}, sm - fm, 3);
        chk({tag, "_first_ce_ppu"}, fp, 18);
        chk({tag, "_ce_ppu_period"}, sp - fp, 18);
    endtask

    int k, lowd, lowc, hi;

    initial begin
        resetn = 1'b1;
        bus.pll_lock = 1'b0;
        bus.calib_done = 1'b0;
        #1 resetn = 1'b0;
        #2;
        chk("reset_ddr_rstn",  int'(bus.ddr_rstn),  0);
        chk("reset_core_rstn", int'(bus.core_rstn), 0);
        chk("reset_ready",     int'(bus.ready),     0);
        chk("reset_ce_main",   int'(bus.ce_main),   0);
        chk("reset_ce_ppu",    int'(bus.ce_ppu),    0);
        chk("reset_retry_cnt", int'(bus.retry_cnt), 0);
        chk_en = 1'b1;
        steps(2);
        resetn = 1'b1;
        steps(3);

        // Clean bring-up
        bus.pll_lock = 1'b1;
        wait_for(S_DDR, 1'b1, 100, "bringup_ddr", k);
        chk("bringup_ddr_edges", k, 27);
        steps(10);
        bus.calib_done = 1'b1;
        wait_for(S_RDY, 1'b1, 10, "bringup_ready", k);
        chk("bringup_ready_edges", k, 1);
        chk("bringup_core_rstn", int'(bus.core_rstn), 1);
        check_ce("bringup");

        // Lock loss in RUN
        bus.pll_lock = 1'b0;
        step(); chk("lockloss_edge1_ready", int'(bus.ready), 1);
        step(); chk("lockloss_edge2_ready", int'(bus.ready), 1);
        step();
        chk("lockloss_edge3_ready", int'(bus.ready), 0);
        chk("lockloss_edge3_core",  int'(bus.core_rstn), 0);
        chk("lockloss_edge3_ddr",   int'(bus.ddr_rstn), 0);
        steps(2);
        bus.pll_lock = 1'b1;
        wait_for(S_DDR, 1'b1, 100, "relock_ddr", k);
        chk("relock_ddr_edges", k, 27);
        wait_for(S_RDY, 1'b1, 10, "relock_ready", k);
        chk("relock_ready_edges", k, 1);
        check_ce("relock");

        // Lock glitch during qualification
        bus.pll_lock = 1'b0;
        steps(3);
        bus.pll_lock = 1'b1;
        steps(8);
        bus.pll_lock = 1'b0;
        steps(3);
        bus.pll_lock = 1'b1;
        wait_for(S_DDR, 1'b1, 100, "glitch_ddr", k);
        chk("glitch_ddr_edges", k, 27);
        wait_for(S_RDY, 1'b1, 10, "glitch_ready", k);
        steps(5);

        // Calibration loss in RUN for one cycle
        bus.calib_done = 1'b0;
        step();
        bus.calib_done = 1'b1;
        lowd = 0; lowc = 0;
        for (int i = 0; i < 30; i++) begin
            if (!bus.ddr_rstn) lowd++;
            if (!bus.core_rstn) lowc++;
            step();
        end
        chk("calloss_ddr_low_cycles", lowd, 8);
        chk("calloss_core_low_cycles", lowc, 9);

        // Asynchronous reset pulse mid-RUN
        @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("areset_ready", int'(bus.ready), 0);
        chk("areset_ddr",   int'(bus.ddr_rstn), 0);
        chk("areset_core",  int'(bus.core_rstn), 0);
        #1 resetn = 1'b1;
        wait_for(S_DDR, 1'b1, 100, "areset_ddr_rise", k);
        chk("areset_ddr_edges", k, 27);
        wait_for(S_RDY, 1'b1, 10, "areset_ready_rise", k);
        chk("areset_ready_edges", k, 1);

        // Randomized lock / calibration disturbances against the model
        for (int i = 0; i < 3000; i++) begin
            if (bus.pll_lock && $urandom_range(0, 299) == 0) bus.pll_lock = 1'b0;
            else if (!bus.pll_lock && $urandom_range(0, 3) == 0) bus.pll_lock = 1'b1;
            if ($urandom_range(0, 59) == 0) bus.calib_done = ~bus.calib_done;
            step();
        end

        // Calibration held low from RUN
        bus.pll_lock = 1'b1;
        bus.calib_done = 1'b1;
        wait_for(S_RDY, 1'b1, 200, "to_setup_ready", k);
        bus.calib_done = 1'b0;
        step();
        wait_for(S_DDR, 1'b1, 20, "to_ddr_rise", k);
        chk("to_ddr_rise_edges", k, 8);
`ifdef NES_CLK_RST_SEQ_CALIB_TIMEOUT_EN
        for (int r = 1; r <= 3; r++) begin
            hi = 0;
            while (bus.ddr_rstn && hi < 200) begin hi++; step(); end
            chk("to_high_cycles", hi, T);
            chk("to_retry_cnt", int'(bus.retry_cnt), r);
            lowd = 0;
            while (!bus.ddr_rstn && lowd < 50) begin lowd++; step(); end
            chk("to_low_cycles", lowd, D);
        end
        steps((255 - 3) * (T + D) + 100);
        chk("to_retry_saturated", int'(bus.retry_cnt), 255);
        steps(2 * (T + D));
        chk("to_retry_still_saturated", int'(bus.retry_cnt), 255);
`else
        lowd = 0;
        for (int i = 0; i < 300; i++) begin
            if (!bus.ddr_rstn) lowd++;
            step();
        end
        chk("noto_ddr_low_cycles", lowd, 0);
        chk("noto_retry_cnt", int'(bus.retry_cnt), 0);
`endif

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
